// File: rtl/aes_regfile_p_if.sv
// Host-side access bus for aes_regfile_p: write/read ports, clear request and status.
interface aes_regfile_p_if #(
  parameter int DW = 8,
  parameter int AW = 2
);
  logic          en;
  logic          we;
  logic [AW-1:0] aw;
  logic [DW-1:0] din;
  logic          re;
  logic [AW-1:0] ar;
  logic [DW-1:0] dout;
  logic          dvld;
  logic          clr;
  logic          busy;
  logic          ign;

  modport master (
    output en, we, aw, din, re, ar, clr,
    input  dout, dvld, busy, ign
  );

  modport slave (
    input  en, we, aw, din, re, ar, clr,
    output dout, dvld, busy, ign
  );
endinterface

// File: rtl/aes_regfile_p.sv
// Parametrised AES status/flag register file: registered write-first reads and a
// one-entry-per-cycle clear sequencer.
module aes_regfile_p #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic             clk,
  input  logic             rstn,
  aes_regfile_p_if.slave   bus
);
  localparam int DEPTH = 2**AW;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t                     state, state_d;
  logic [DEPTH-1:0][DW-1:0]   mem;
  logic [AW-1:0]              idx;
  logic [DW-1:0]              dout;
  logic                       dvld, busy, ign;
  logic                       req, wr, rd, start, last;

  assign req   = bus.en & (bus.we | bus.re);
  assign wr    = bus.en & bus.we & ~busy;
  assign rd    = bus.en & bus.re & ~busy;
  assign start = bus.clr & (state == IDLE);
  assign last  = (idx == {AW{1'b1}});

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = CLEAR;
      CLEAR:   if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // start wins over any same-cycle access; busy tracks the registered state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem  <= '0;
      idx  <= '0;
      dout <= '0;
      dvld <= 1'b0;
      busy <= 1'b0;
      ign  <= 1'b0;
    end else begin
      busy <= (state_d == CLEAR);
      ign  <= req & (busy | start);
      if (start)
        idx <= '0;
      else if (state == CLEAR) begin
        mem[idx] <= '0;
        idx      <= idx + 1'b1;
      end
      if (wr & ~start)
        mem[bus.aw] <= bus.din;
      if (rd & ~start) begin
        dout <= (wr && bus.aw == bus.ar) ? bus.din : mem[bus.ar];
        dvld <= 1'b1;
      end else begin
        dvld <= 1'b0;
      end
    end
  end

  assign bus.dout = dout;
  assign bus.dvld = dvld;
  assign bus.busy = busy;
  assign bus.ign  = ign;
endmodule

// File: tb/tb_aes_regfile_p.sv
// Directed vector bench for aes_regfile_p (DW=8, AW=2).
module tb_aes_regfile_p;
  logic clk = 1'b0;
  logic rstn;
  int   errs = 0;
  int   checks = 0;

  aes_regfile_p_if #(.DW(8), .AW(2)) bus ();

  aes_regfile_p #(.DW(8), .AW(2)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en, we;
    logic [1:0] aw;
    logic [7:0] din;
    logic       re;
    logic [1:0] ar;
    logic       clr;
    logic       e_dvld;
    logic [7:0] e_dout;
    logic       e_ign, e_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic en, logic we, logic [1:0] aw, logic [7:0] din,
                              logic re, logic [1:0] ar, logic clr,
                              logic e_dvld, logic [7:0] e_dout, logic e_ign, logic e_busy);
    vec_t v;
    v.en = en; v.we = we; v.aw = aw; v.din = din; v.re = re; v.ar = ar; v.clr = clr;
    v.e_dvld = e_dvld; v.e_dout = e_dout; v.e_ign = e_ign; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic we, input logic [1:0] aw, input logic [7:0] din,
                       input logic re, input logic [1:0] ar, input logic clr);
    bus.en = en; bus.we = we; bus.aw = aw; bus.din = din;
    bus.re = re; bus.ar = ar; bus.clr = clr;
  endtask

  // One cycle: apply inputs, take the edge, sample 1 time unit later.
  task automatic step(input logic en, input logic we, input logic [1:0] aw, input logic [7:0] din,
                      input logic re, input logic [1:0] ar, input logic clr);
    drive(en, we, aw, din, re, ar, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic e_dvld, input logic [7:0] e_dout,
                         input logic e_ign, input logic e_busy);
    chk({tag, ".dvld"}, 32'(bus.dvld), 32'(e_dvld));
    chk({tag, ".dout"}, 32'(bus.dout), 32'(e_dout));
    chk({tag, ".ign"},  32'(bus.ign),  32'(e_ign));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(e_busy));
  endtask

  initial begin
    // en we aw din re ar clr | dvld dout ign busy
    // reset contents read as zero
    for (int a = 0; a < 4; a++) tbl.push_back(mk(1,0,0,8'h00,1,2'(a),0, 1,8'h00,0,0));
    tbl.push_back(mk(1,1,0,8'hA5,0,0,0, 0,8'h00,0,0));
    tbl.push_back(mk(1,1,1,8'h5A,0,0,0, 0,8'h00,0,0));
    tbl.push_back(mk(1,1,2,8'h3C,0,0,0, 0,8'h00,0,0));
    tbl.push_back(mk(1,1,3,8'hC3,0,0,0, 0,8'h00,0,0));
    tbl.push_back(mk(1,0,0,8'h00,1,3,0, 1,8'hC3,0,0));
    tbl.push_back(mk(1,0,0,8'h00,1,2,0, 1,8'h3C,0,0));
    tbl.push_back(mk(1,0,0,8'h00,1,1,0, 1,8'h5A,0,0));
    tbl.push_back(mk(1,0,0,8'h00,1,0,0, 1,8'hA5,0,0));
    // write-first bypass, then persisted value
    tbl.push_back(mk(1,1,1,8'h77,1,1,0, 1,8'h77,0,0));
    tbl.push_back(mk(0,0,0,8'h00,0,0,0, 0,8'h77,0,0));
    tbl.push_back(mk(1,0,0,8'h00,1,1,0, 1,8'h77,0,0));
    // clear: busy for 4 samples, read in 2nd busy cycle dropped
    tbl.push_back(mk(0,0,0,8'h00,0,0,1, 0,8'h77,0,1));
    tbl.push_back(mk(0,0,0,8'h00,0,0,0, 0,8'h77,0,1));
    tbl.push_back(mk(1,0,0,8'h00,1,0,0, 0,8'h77,1,1));
    tbl.push_back(mk(0,0,0,8'h00,0,0,0, 0,8'h77,0,1));
    tbl.push_back(mk(0,0,0,8'h00,0,0,0, 0,8'h77,0,0));
    for (int a = 0; a < 4; a++) tbl.push_back(mk(1,0,0,8'h00,1,2'(a),0, 1,8'h00,0,0));
    // clr with same-cycle write: write dropped; re-pulsed clr doesn't extend
    tbl.push_back(mk(1,1,2,8'h11,1,2,0, 1,8'h11,0,0));
    tbl.push_back(mk(1,1,2,8'hFF,0,0,1, 0,8'h11,1,1));
    tbl.push_back(mk(0,0,0,8'h00,0,0,0, 0,8'h11,0,1));
    tbl.push_back(mk(0,0,0,8'h00,0,0,1, 0,8'h11,0,1));
    tbl.push_back(mk(0,0,0,8'h00,0,0,0, 0,8'h11,0,1));
    tbl.push_back(mk(0,0,0,8'h00,0,0,0, 0,8'h11,0,0));
    tbl.push_back(mk(1,0,0,8'h00,1,2,0, 1,8'h00,0,0));
    // en=0 masks both write and read
    tbl.push_back(mk(1,1,0,8'h42,0,0,0, 0,8'h00,0,0));
    tbl.push_back(mk(0,1,0,8'h99,1,0,0, 0,8'h00,0,0));
    tbl.push_back(mk(1,0,0,8'h00,1,0,0, 1,8'h42,0,0));

    drive(0,0,0,8'h00,0,0,0);
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 0, 8'h00, 0, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].we, tbl[i].aw, tbl[i].din, tbl[i].re, tbl[i].ar, tbl[i].clr);
      chk_out($sformatf("vec%0d", i), tbl[i].e_dvld, tbl[i].e_dout, tbl[i].e_ign, tbl[i].e_busy);
    end

    // reset mid-clear: fill, start clear, drop rstn in the 2nd busy cycle
    for (int a = 0; a < 4; a++) step(1,1,2'(a),8'(8'h10 + a),0,0,0);
    step(1,0,0,8'h00,1,3,0);
    chk_out("mrc.pre", 1, 8'h13, 0, 0);
    step(0,0,0,8'h00,0,0,1);
    chk_out("mrc.busy1", 0, 8'h13, 0, 1);
    step(1,0,0,8'h00,1,1,0);
    chk_out("mrc.busy2", 0, 8'h13, 1, 1);
    drive(0,0,0,8'h00,0,0,0);
    rstn = 1'b0;
    #1;
    chk_out("mrc.rst", 0, 8'h00, 0, 0);
    @(negedge clk);
    rstn = 1'b1;
    for (int a = 0; a < 4; a++) begin
      @(negedge clk);
      drive(1,0,0,8'h00,1,2'(a),0);
      @(posedge clk);
      #1;
      chk_out($sformatf("mrc.rd%0d", a), 1, 8'h00, 0, 0);
    end
    drive(0,0,0,8'h00,0,0,0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/aes_regfile_p.md
Name: aes_regfile_p

Overview:
- Parametrised successor to the 4x8 AES status register file: DEPTH = 2**AW entries of DW bits each.
- Writes are synchronous. Reads are registered, with a one-cycle valid strobe and write-first bypass.
- A built-in clear sequencer zeroes every entry, one entry per cycle, without a reset.
- Sits between the AES control sequencer and the host register interface; holds status and key-schedule flags.

Parameters:
- DW, 8, data width in bits (>=1)
- AW, 2, address width; DEPTH = 2**AW entries (AW>=1)

Ports:
- clk  in  1  clock; all state on rising edge
- rstn  in  1  asynchronous active-low reset
- en  in  1  access enable; qualifies we and re, not clr
- we  in  1  write request
- aw  in  AW  write address
- din  in  DW  write data
- re  in  1  read request
- ar  in  AW  read address
- dout  out  DW  registered read data
- dvld  out  1  one-cycle pulse: dout updated by a read
- clr  in  1  start clear sequence (sampled in IDLE only)
- busy  out  1  clear sequence in progress
- ign  out  1  one-cycle pulse: an access was dropped

Behaviour:
- Reset (rstn=0, asynchronous): all entries, dout, dvld, busy, ign and the clear index are 0; FSM is IDLE.
- Internal terms:
  - wr = en & we & ~busy
  - rd = en & re & ~busy
  - start = clr & (state==IDLE)
- Write: if wr & ~start, then mem[aw] <= din at the edge.
- Read:
  - If rd & ~start, then at the edge dout <= mem[ar] and dvld <= 1. Latency is 1 cycle.
  - Bypass: if wr and aw==ar in the same cycle, dout <= din (write-first).
  - Otherwise dvld <= 0 and dout holds its last value. dout is never cleared except by rstn.
- FSM:
  - States IDLE and CLEAR.
  - IDLE -> CLEAR on start: idx <= 0, busy <= 1.
  - In CLEAR, each cycle mem[idx] <= 0 and idx <= idx+1.
  - When idx==DEPTH-1, that entry is cleared, the FSM returns to IDLE and busy <= 0 on the same edge.
  - busy is high for exactly DEPTH cycles, starting the cycle after clr is sampled.
- Priority:
  - start beats wr and rd in the same cycle. The write and read are not performed, and ign <= 1 if (en & (we|re)).
  - clr while in CLEAR is ignored; the sequence does not restart or extend.
- While busy:
  - Any en & (we|re) is dropped; ign <= 1 next cycle and dvld stays 0.
  - mem is not modified except by the sequencer.
- ign is 0 in every cycle where no access was dropped.
- The back-to-back cycle after busy falls accepts accesses normally.
- en=0: no read or write and no ign, regardless of we/re; clear still runs.
- Address wrap: the clear index wraps only through the explicit DEPTH-1 termination; no out-of-range addresses exist.
- rstn asserted mid-clear: immediate return to reset state; every entry reads 0 afterwards.

Test Plan:
Stimulus for all scenarios: DW=8, AW=2.
- Reset, then read addr 0-3 -> dout=0x00 with dvld=1 one cycle after each re; busy=0, ign=0.
- Write 0xA5, 0x5A, 0x3C, 0xC3 to addr 0-3, then read 3,2,1,0 back-to-back -> dout=0xC3, 0x3C, 0x5A, 0xA5 on consecutive cycles, dvld high for 4 cycles.
- Same-cycle write 0x77 to addr 1 and read addr 1 -> next cycle dout=0x77, dvld=1; a later read of addr 1 also gives 0x77.
- After filling with nonzero data, pulse clr one cycle:
  - busy=1 for exactly 4 cycles.
  - A read issued in the second busy cycle -> ign=1 next cycle, dvld=0, dout unchanged.
  - After busy falls, all 4 entries read 0x00.
- Assert clr with en=we=1, aw=2, din=0xFF in the same cycle -> write dropped, ign=1; after the clear, addr 2 reads 0x00. A clr re-pulsed mid-sequence does not extend busy beyond 4 cycles.
- Start a clear and drop rstn during its second cycle -> busy=0, dvld=0, ign=0 immediately; all entries read 0x00 after release.
